// File: rtl/pipe_ctrl_pkg.sv
// Shared types and defaults for the pipeline hazard controller.
package pipe_ctrl_pkg;

    localparam int unsigned REG_W_DEFAULT = 5;
    localparam int unsigned PEN_CNT_W     = 4;

    typedef enum logic [1:0] {
        StRun      = 2'd0,
        StMemWait  = 2'd1,
        StFlushing = 2'd2
    } state_e;

endpackage

// File: rtl/pipe_ctrl_if.sv
// Hazard/control bundle between the pipeline datapath (master) and pipe_ctrl (slave).
interface pipe_ctrl_if #(
    parameter int unsigned REG_W = pipe_ctrl_pkg::REG_W_DEFAULT
);
    logic             MEM_BUSY;
    logic             ICACHE_BUSY;
    logic             MISPREDICT;
    logic             LOAD_IN_EX;
    logic [REG_W-1:0] EX_RT;
    logic [REG_W-1:0] ID_RS;
    logic [REG_W-1:0] ID_RT;
    logic             STALL_IF;
    logic             STALL_ID;
    logic             FLUSH_ID;
    logic             FLUSH_EX;
    logic             REDIRECT;

    modport master (
        output MEM_BUSY, ICACHE_BUSY, MISPREDICT, LOAD_IN_EX, EX_RT, ID_RS, ID_RT,
        input  STALL_IF, STALL_ID, FLUSH_ID, FLUSH_EX, REDIRECT
    );

    modport slave (
        input  MEM_BUSY, ICACHE_BUSY, MISPREDICT, LOAD_IN_EX, EX_RT, ID_RS, ID_RT,
        output STALL_IF, STALL_ID, FLUSH_ID, FLUSH_EX, REDIRECT
    );
endinterface

// File: rtl/pipe_ctrl_hazard_detect.sv
// Load-use comparator: a load in EX whose nonzero destination feeds an ID source.
module hazard_detect #(
    parameter int unsigned REG_W = pipe_ctrl_pkg::REG_W_DEFAULT
) (
    input  logic             load_in_ex,
    input  logic [REG_W-1:0] ex_rt,
    input  logic [REG_W-1:0] id_rs,
    input  logic [REG_W-1:0] id_rt,
    output logic             hazard
);
    assign hazard = load_in_ex && (ex_rt != '0) && ((ex_rt == id_rs) || (ex_rt == id_rt));
endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline stall/flush controller (RUN / MEMWAIT / FLUSHING).
// Define PIPE_CTRL_STATS_EN to build the saturating stall/redirect counters.
module pipe_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int unsigned MISP_PENALTY = 2,
    parameter int unsigned REG_W        = REG_W_DEFAULT
) (
    input  logic        CLK,
    input  logic        RESET,
    pipe_ctrl_if.slave  bus,
    output logic [31:0] STALL_CNT,
    output logic [31:0] FLUSH_CNT
);
    localparam logic [PEN_CNT_W-1:0] PenLoad = PEN_CNT_W'(MISP_PENALTY - 1);

    state_e               state_q, state_d, saved_q, saved_d, eff_state;
    logic [PEN_CNT_W-1:0] cnt_q, cnt_d;
    logic                 pend_q, pend_d;
    logic                 load_use, misp;
    logic                 stall_if, stall_id, flush_id, flush_ex, redirect;

    hazard_detect #(.REG_W(REG_W)) u_hazard (
        .load_in_ex (bus.LOAD_IN_EX),
        .ex_rt      (bus.EX_RT),
        .id_rs      (bus.ID_RS),
        .id_rt      (bus.ID_RT),
        .hazard     (load_use)
    );

    always_comb begin
        state_d   = state_q;
        saved_d   = saved_q;
        cnt_d     = cnt_q;
        pend_d    = pend_q;
        stall_if  = 1'b0;
        stall_id  = 1'b0;
        flush_id  = 1'b0;
        flush_ex  = 1'b0;
        redirect  = 1'b0;
        // Leaving MEMWAIT, this cycle already behaves as the state it resumes.
        eff_state = (state_q == StMemWait) ? saved_q : state_q;
        misp      = bus.MISPREDICT || pend_q;

        if (RESET) begin
            flush_id = 1'b1;
            flush_ex = 1'b1;
        end else if (bus.MEM_BUSY) begin
            stall_if = 1'b1;
            stall_id = 1'b1;
            state_d  = StMemWait;
            saved_d  = eff_state;
            pend_d   = misp;
        end else begin
            state_d = eff_state;
            pend_d  = 1'b0;
            if (misp) begin
                flush_id = 1'b1;
                flush_ex = 1'b1;
                redirect = 1'b1;
                if (MISP_PENALTY > 1) begin
                    state_d = StFlushing;
                    cnt_d   = PenLoad;
                end else begin
                    state_d = StRun;
                    cnt_d   = '0;
                end
            end else if (eff_state == StFlushing) begin
                flush_id = 1'b1;
                if (cnt_q <= PEN_CNT_W'(1)) begin
                    state_d = StRun;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q - PEN_CNT_W'(1);
                end
            end else if (load_use) begin
                stall_if = 1'b1;
                stall_id = 1'b1;
                flush_ex = 1'b1;
            end else if (bus.ICACHE_BUSY) begin
                stall_if = 1'b1;
                flush_id = 1'b1;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q <= StRun;
            saved_q <= StRun;
            cnt_q   <= '0;
            pend_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            saved_q <= saved_d;
            cnt_q   <= cnt_d;
            pend_q  <= pend_d;
        end
    end

    assign bus.STALL_IF = stall_if;
    assign bus.STALL_ID = stall_id;
    assign bus.FLUSH_ID = flush_id;
    assign bus.FLUSH_EX = flush_ex;
    assign bus.REDIRECT = redirect;

`ifdef PIPE_CTRL_STATS_EN
    logic [31:0] stall_cnt_q, flush_cnt_q;

    always_ff @(posedge CLK) begin
        if (RESET) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            if (stall_if && (stall_cnt_q != 32'hFFFF_FFFF)) stall_cnt_q <= stall_cnt_q + 32'd1;
            if (redirect && (flush_cnt_q != 32'hFFFF_FFFF)) flush_cnt_q <= flush_cnt_q + 32'd1;
        end
    end

    assign STALL_CNT = stall_cnt_q;
    assign FLUSH_CNT = flush_cnt_q;
`else
    assign STALL_CNT = '0;
    assign FLUSH_CNT = '0;
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// Self-checking bench for pipe_ctrl (MISP_PENALTY=2); honours PIPE_CTRL_STATS_EN.
module tb_pipe_ctrl;
    import pipe_ctrl_pkg::*;

    typedef struct {
        logic       rst;
        logic       mb;
        logic       ib;
        logic       mp;
        logic       ld;
        logic [4:0] ex_rt;
        logic [4:0] rs;
        logic [4:0] rt;
        logic [4:0] exp;  // {STALL_IF, STALL_ID, FLUSH_ID, FLUSH_EX, REDIRECT}
    } vec_t;

    logic        CLK = 1'b0;
    logic        RESET;
    logic [31:0] stall_cnt, flush_cnt;
    logic [31:0] exp_stall_cnt = '0, exp_flush_cnt = '0;
    logic [4:0]  sb_q[$];
    vec_t        tbl[$];
    int          n_cmp = 0, n_fail = 0;

`ifdef PIPE_CTRL_STATS_EN
    localparam bit StatsOn = 1'b1;
`else
    localparam bit StatsOn = 1'b0;
`endif

    pipe_ctrl_if #(.REG_W(5)) bus ();

    pipe_ctrl #(.MISP_PENALTY(2), .REG_W(5)) dut (
        .CLK       (CLK),
        .RESET     (RESET),
        .bus       (bus.slave),
        .STALL_CNT (stall_cnt),
        .FLUSH_CNT (flush_cnt)
    );

    always #5 CLK = ~CLK;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    function automatic vec_t mk(input logic rst, mb, ib, mp, ld, input logic [4:0] ex_rt, rs,
                                rt, input logic [4:0] exp);
        vec_t v;
        v.rst = rst; v.mb = mb; v.ib = ib; v.mp = mp; v.ld = ld;
        v.ex_rt = ex_rt; v.rs = rs; v.rt = rt; v.exp = exp;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        n_cmp++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, want, $time);
        end
    endtask

    // One clock cycle: drive after the edge, push expectation, sample on the falling edge.
    task automatic step(input string name, input vec_t v);
        logic [4:0] got, want;
        @(posedge CLK);
        #1;
        RESET           = v.rst;
        bus.MEM_BUSY    = v.mb;
        bus.ICACHE_BUSY = v.ib;
        bus.MISPREDICT  = v.mp;
        bus.LOAD_IN_EX  = v.ld;
        bus.EX_RT       = v.ex_rt;
        bus.ID_RS       = v.rs;
        bus.ID_RT       = v.rt;
        sb_q.push_back(v.exp);
        @(negedge CLK);
        got  = {bus.STALL_IF, bus.STALL_ID, bus.FLUSH_ID, bus.FLUSH_EX, bus.REDIRECT};
        want = sb_q.pop_front();
        check({name, " outs"}, 32'(got), 32'(want));
        check({name, " stall_cnt"}, stall_cnt, StatsOn ? exp_stall_cnt : 32'd0);
        check({name, " flush_cnt"}, flush_cnt, StatsOn ? exp_flush_cnt : 32'd0);
        if (v.rst) begin
            exp_stall_cnt = '0;
            exp_flush_cnt = '0;
        end else begin
            exp_stall_cnt += 32'(want[4]);
            exp_flush_cnt += 32'(want[0]);
        end
    endtask

    task automatic idle(input string name, input logic [4:0] exp);
        step(name, mk(0, 0, 0, 0, 0, 0, 0, 0, exp));
    endtask

    initial begin
        RESET = 1'b1;
        bus.MEM_BUSY = 0; bus.ICACHE_BUSY = 0; bus.MISPREDICT = 0; bus.LOAD_IN_EX = 0;
        bus.EX_RT = 0; bus.ID_RS = 0; bus.ID_RT = 0;

        //                rst mb ib mp ld ex rs rt   exp
        tbl.push_back(mk(1, 0, 0, 1, 0, 0, 0, 0, 5'b00110));  // reset x3 with mispredict
        tbl.push_back(mk(1, 1, 1, 1, 1, 5, 5, 5, 5'b00110));
        tbl.push_back(mk(1, 0, 0, 1, 0, 0, 0, 0, 5'b00110));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 5'b00000));
        tbl.push_back(mk(0, 0, 0, 0, 1, 5, 1, 5, 5'b11010));  // load-use on RT
        tbl.push_back(mk(0, 0, 0, 0, 0, 5, 1, 5, 5'b00000));
        tbl.push_back(mk(0, 0, 0, 0, 1, 9, 9, 2, 5'b11010));  // load-use on RS
        tbl.push_back(mk(0, 0, 0, 0, 1, 0, 0, 0, 5'b00000));  // EX_RT=0: no hazard
        tbl.push_back(mk(0, 0, 0, 0, 1, 3, 4, 6, 5'b00000));
        tbl.push_back(mk(0, 0, 1, 0, 0, 0, 0, 0, 5'b10100));  // icache busy bubble
        tbl.push_back(mk(0, 0, 1, 0, 1, 7, 7, 0, 5'b11010));  // load-use beats icache
        tbl.push_back(mk(0, 0, 1, 1, 1, 7, 7, 0, 5'b00111));  // mispredict beats both
        tbl.push_back(mk(0, 0, 1, 0, 1, 7, 7, 0, 5'b00100));  // FLUSHING ignores them
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 5'b00000));
        tbl.push_back(mk(0, 0, 0, 1, 0, 0, 0, 0, 5'b00111));
        tbl.push_back(mk(0, 0, 0, 1, 0, 0, 0, 0, 5'b00111));  // restart in FLUSHING
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 5'b00100));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 5'b00000));
        tbl.push_back(mk(0, 1, 1, 0, 1, 5, 5, 5, 5'b11000));  // MEM_BUSY dominates
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 5'b00000));
        foreach (tbl[i]) step($sformatf("vec%0d", i), tbl[i]);

        // Mispredict during a 4-cycle memory stall is deferred to cycle 5.
        step("mb_misp1", mk(0, 1, 0, 1, 0, 0, 0, 0, 5'b11000));
        for (int i = 0; i < 3; i++) step("mb_hold", mk(0, 1, 0, 0, 0, 0, 0, 0, 5'b11000));
        idle("mb_release", 5'b00111);
        idle("mb_flush", 5'b00100);
        idle("mb_run", 5'b00000);

        // Memory stall in the middle of FLUSHING freezes the remaining flush cycle.
        step("fl_misp", mk(0, 0, 0, 1, 0, 0, 0, 0, 5'b00111));
        for (int i = 0; i < 3; i++) step("fl_hold", mk(0, 1, 0, 0, 0, 0, 0, 0, 5'b11000));
        idle("fl_resume", 5'b00100);
        idle("fl_run", 5'b00000);

        // Reset mid-FLUSHING and mid-MEMWAIT (with pending mispredict) drops all state.
        step("rf_misp", mk(0, 0, 0, 1, 0, 0, 0, 0, 5'b00111));
        step("rf_rst", mk(1, 0, 0, 0, 0, 0, 0, 0, 5'b00110));
        idle("rf_run", 5'b00000);
        step("rm_mb", mk(0, 1, 0, 1, 0, 0, 0, 0, 5'b11000));
        step("rm_rst", mk(1, 0, 0, 0, 0, 0, 0, 0, 5'b00110));
        idle("rm_run", 5'b00000);

        // Counter scenario: 10 stall cycles and 2 mispredicts after a reset.
        step("cnt_rst", mk(1, 0, 0, 0, 0, 0, 0, 0, 5'b00110));
        for (int i = 0; i < 4; i++) step("cnt_mb", mk(0, 1, 0, 0, 0, 0, 0, 0, 5'b11000));
        for (int i = 0; i < 3; i++) step("cnt_lu", mk(0, 0, 0, 0, 1, 4, 4, 0, 5'b11010));
        for (int i = 0; i < 3; i++) step("cnt_ic", mk(0, 0, 1, 0, 0, 0, 0, 0, 5'b10100));
        for (int i = 0; i < 2; i++) begin
            step("cnt_misp", mk(0, 0, 0, 1, 0, 0, 0, 0, 5'b00111));
            idle("cnt_flush", 5'b00100);
        end
        idle("cnt_end", 5'b00000);
        check("stall_cnt final", stall_cnt, StatsOn ? 32'd10 : 32'd0);
        check("flush_cnt final", flush_cnt, StatsOn ? 32'd2 : 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
